// File: rtl/uart_rx_fsm.sv
// UART receive control FSM: start detection, oversample/bit counters and checker strobes.
// Optional macro UART_RX_ERR_FLAGS_EN adds par_err_flag / stp_err_flag outputs.
module uart_rx_fsm #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned PRESC_W    = 6
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               RX_IN,
   input  logic               PAR_EN,
   input  logic [PRESC_W-1:0] Prescale,
   input  logic               strt_glitch,
   input  logic               par_err,
   input  logic               stp_err,
   output logic [PRESC_W-1:0] edge_cnt,
   output logic [3:0]         bit_cnt,
   output logic               dat_samp_en,
   output logic               deser_en,
   output logic               strt_chk_en,
   output logic               par_chk_en,
   output logic               stp_chk_en,
`ifdef UART_RX_ERR_FLAGS_EN
   output logic               par_err_flag,
   output logic               stp_err_flag,
`endif
   output logic               data_valid
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 r_par_flag;
   logic                 w_par_flag_nxt;
   logic [PRESC_W-1:0]   w_chk_pt;
   logic [PRESC_W-1:0]   w_end_pt;
   logic [PRESC_W-1:0]   w_edge_nxt;
   logic [3:0]           w_bit_nxt;
   logic                 w_bit_end;
   logic                 w_at_chk;
   logic                 w_dv_nxt;
   logic                 w_perr_nxt;
   logic                 w_serr_nxt;

   assign w_chk_pt  = (Prescale >> 1) + PRESC_W'(2);
   assign w_end_pt  = Prescale - PRESC_W'(1);
   // >= rather than == so a mid-frame Prescale reduction still wraps instead of running away
   assign w_bit_end = (edge_cnt >= w_end_pt);

   always_comb begin
      w_state_nxt    = r_state;
      w_edge_nxt     = w_bit_end ? '0 : edge_cnt + PRESC_W'(1);
      w_bit_nxt      = bit_cnt;
      w_par_flag_nxt = r_par_flag;
      w_dv_nxt       = 1'b0;
      w_perr_nxt     = 1'b0;
      w_serr_nxt     = 1'b0;
      case (r_state)
         IDLE: begin
            w_edge_nxt     = '0;
            w_bit_nxt      = '0;
            w_par_flag_nxt = 1'b0;
            if (!RX_IN) w_state_nxt = START;
         end
         START: begin
            if (w_bit_end) begin
               w_bit_nxt   = '0;
               w_state_nxt = strt_glitch ? IDLE : DATA;
            end
         end
         DATA: begin
            if (w_bit_end) begin
               if (bit_cnt >= 4'(DATA_WIDTH - 1)) begin
                  w_bit_nxt   = '0;
                  w_state_nxt = PAR_EN ? PARITY : STOP;
               end else begin
                  w_bit_nxt = bit_cnt + 4'd1;
               end
            end
         end
         PARITY: begin
            if (w_bit_end) begin
               w_par_flag_nxt = par_err;
               w_state_nxt    = STOP;
            end
         end
         STOP: begin
            if (w_bit_end) begin
               w_dv_nxt       = !stp_err && !r_par_flag;
               w_perr_nxt     = r_par_flag;
               w_serr_nxt     = stp_err;
               w_par_flag_nxt = 1'b0;
               w_state_nxt    = IDLE;
            end
         end
         default: begin
            w_state_nxt    = IDLE;
            w_edge_nxt     = '0;
            w_bit_nxt      = '0;
            w_par_flag_nxt = 1'b0;
         end
      endcase
   end

   // strobes are decoded from next-state values so the registered pulse lines up with edge_cnt==S
   assign w_at_chk = (w_edge_nxt == w_chk_pt);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state     <= IDLE;
         r_par_flag  <= 1'b0;
         edge_cnt    <= '0;
         bit_cnt     <= '0;
         dat_samp_en <= 1'b0;
         deser_en    <= 1'b0;
         strt_chk_en <= 1'b0;
         par_chk_en  <= 1'b0;
         stp_chk_en  <= 1'b0;
         data_valid  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_par_flag  <= w_par_flag_nxt;
         edge_cnt    <= w_edge_nxt;
         bit_cnt     <= w_bit_nxt;
         dat_samp_en <= (w_state_nxt != IDLE);
         deser_en    <= (w_state_nxt == DATA)   && w_at_chk;
         strt_chk_en <= (w_state_nxt == START)  && w_at_chk;
         par_chk_en  <= (w_state_nxt == PARITY) && w_at_chk;
         stp_chk_en  <= (w_state_nxt == STOP)   && w_at_chk;
         data_valid  <= w_dv_nxt;
      end
   end

`ifdef UART_RX_ERR_FLAGS_EN
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         par_err_flag <= 1'b0;
         stp_err_flag <= 1'b0;
      end else begin
         par_err_flag <= w_perr_nxt;
         stp_err_flag <= w_serr_nxt;
      end
   end
`else
   logic w_unused_flags;
   assign w_unused_flags = w_perr_nxt ^ w_serr_nxt;
`endif

endmodule
